t07_fsm_playing_grid: RTL

Parametrised successor of the playing-state controller: arbitrates between the module-select screen (MOD) and an ROWS x COLS grid of sub-games.
- Tracks which slots are cleared and counts clears; registered game_clear flags when the required count is reached.
- Blocks re-entry into already-cleared slots.
- Returns automatically to MOD on a clear.
- Sits between the top-level game FSM (MENU/PLAY/LOST/WON) and the sub-game blocks.

---
 rtl/t07_game_pkg.sv | 24 ++
 rtl/t07_fsm_playing_grid_popcount.sv | 17 +
 rtl/t07_fsm_playing_grid.sv | 133 +++++++++++++
 3 files changed

// File: rtl/t07_game_pkg.sv
// Shared types and button codes for the playing-grid controller and its neighbours.
package t07_game_pkg;

  typedef enum logic [2:0] {
    MENU = 3'd0,
    PLAY = 3'd1,
    LOST = 3'd2,
    WON  = 3'd3
  } game_state_t;

  typedef enum logic {
    P_MOD    = 1'b0,
    P_ACTIVE = 1'b1
  } play_mode_t;

  localparam logic [5:0] BTN_SELECT = 6'b000001;
  localparam logic [5:0] BTN_UP     = 6'b000010;
  localparam logic [5:0] BTN_RIGHT  = 6'b000100;
  localparam logic [5:0] BTN_DOWN   = 6'b001000;
  localparam logic [5:0] BTN_LEFT   = 6'b010000;
  localparam logic [5:0] BTN_BACK   = 6'b100000;
  localparam logic [5:0] BTN_NONE   = 6'b000000;

endpackage

// File: rtl/t07_fsm_playing_grid_popcount.sv
// Combinational population count; derives the clear count straight from the bitmap.
module t07_popcount #(
  parameter int WIDTH = 4,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits_i,
  output logic [OUT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + OUT_W'(bits_i[i]);
    end
  end

endmodule

// File: rtl/t07_fsm_playing_grid.sv
// Arbitrates between the module-select screen and a ROWS x COLS grid of sub-games.
// Optional strike counter / game_lost output enabled with `define T07_STRIKE_EN.
module t07_fsm_playing_grid
  import t07_game_pkg::*;
#(
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int NUM_SLOT   = ROWS * COLS,
  parameter int STRIKE_MAX = 3,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int SW = $clog2(NUM_SLOT + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe,
  input  logic [5:0]          button,
  input  logic [2:0]          game_state_in,
  input  logic [RW-1:0]       cursor_row,
  input  logic [CW-1:0]       cursor_col,
  input  logic [SW-1:0]       mod_num,
  input  logic                sub_clear_edge,
  input  logic                sub_strike_edge,
  output logic [NUM_SLOT-1:0] slot_cleared,
  output logic [SW-1:0]       playing_state_out,
  output logic [SW-1:0]       num_clear,
  output logic                game_clear,
  output logic                game_lost
);

  play_mode_t          mode_q;
  logic [SW-1:0]       activeSlot_q;
  logic [SW-1:0]       playState_q;
  logic [NUM_SLOT-1:0] slotCleared_q;
  logic                gameClear_q;
  logic [SW-1:0]       numClear;
  logic [SW-1:0]       selIdx;
  logic                selInRange;
  logic                selFree;

`ifdef T07_STRIKE_EN
  localparam int KW = $clog2(STRIKE_MAX + 1);
  logic [KW-1:0] strikes_q;
  logic          gameLost_q;
`else
  logic unused_strike;
  assign unused_strike = sub_strike_edge;
`endif

  t07_popcount #(.WIDTH(NUM_SLOT), .OUT_W(SW)) u_popcount (
    .bits_i  (slotCleared_q),
    .count_o (numClear)
  );

  // Out-of-range cursor positions can exist when ROWS/COLS are not powers of two.
  always_comb begin
    selInRange = (int'(cursor_row) < ROWS) && (int'(cursor_col) < COLS);
    selIdx     = SW'(int'(cursor_row) * COLS + int'(cursor_col));
    selFree    = selInRange && !slotCleared_q[selIdx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q        <= P_MOD;
      activeSlot_q  <= '0;
      playState_q   <= '0;
      slotCleared_q <= '0;
      gameClear_q   <= 1'b0;
`ifdef T07_STRIKE_EN
      strikes_q     <= '0;
      gameLost_q    <= 1'b0;
`endif
    end else begin
      case (game_state_in)
        MENU: begin
          mode_q        <= P_MOD;
          activeSlot_q  <= '0;
          playState_q   <= '0;
          slotCleared_q <= '0;
          gameClear_q   <= 1'b0;
`ifdef T07_STRIKE_EN
          strikes_q     <= '0;
          gameLost_q    <= 1'b0;
`endif
        end
        PLAY: begin
          gameClear_q <= (numClear >= mod_num) && (mod_num != '0);
`ifdef T07_STRIKE_EN
          gameLost_q  <= (strikes_q == KW'(STRIKE_MAX));
`endif
          case (mode_q)
            P_MOD: begin
              if (strobe && (button == BTN_SELECT) && selFree) begin
                mode_q       <= P_ACTIVE;
                activeSlot_q <= selIdx;
                playState_q  <= selIdx + SW'(1);
              end
            end
            P_ACTIVE: begin
              // BACK outranks a simultaneous clear; the sub-game re-asserts on re-entry.
              if (strobe && (button == BTN_BACK)) begin
                mode_q      <= P_MOD;
                playState_q <= '0;
              end else if (sub_clear_edge) begin
                slotCleared_q[activeSlot_q] <= 1'b1;
                mode_q                      <= P_MOD;
                playState_q                 <= '0;
              end
`ifdef T07_STRIKE_EN
              else if (sub_strike_edge && (strikes_q != KW'(STRIKE_MAX))) begin
                strikes_q <= strikes_q + KW'(1);
              end
`endif
            end
            default: mode_q <= P_MOD;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign slot_cleared      = slotCleared_q;
  assign playing_state_out = playState_q;
  assign num_clear         = numClear;
  assign game_clear        = gameClear_q;
`ifdef T07_STRIKE_EN
  assign game_lost         = gameLost_q;
`else
  assign game_lost         = 1'b0;
`endif

endmodule
